mil_txd_burst: RTL
==================

MIL_TXD_BURST -- requirements
Module: mil_txd_burst

Interface
REQ-001 Parameter DW, 16, data bits per word (4..32).
REQ-002 Parameter DIV, 25, clk cycles per half-bit (>=2).
REQ-003 Parameter DEPTH, 4, word FIFO depth (power of two, >=2).
REQ-004 Parameter PAR_ODD, 1, 1 = odd parity over data bits, 0 = even.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous reset, active low.
REQ-007 wr_en  in  1  FIFO write strobe, one word per cycle.
REQ-008 wr_dat  in  DW  word to transmit.
REQ-009 wr_cw  in  1  sync type stored with word: 1 = command/status sync (SY1), 0 = data sync (SY2).
REQ-010 abort  in  1  stop transmission and flush FIFO.
REQ-011 full / empty  out  1  FIFO status, registered.
REQ-012 level  out  clog2(DEPTH+1)  words held in FIFO.
REQ-013 ovf  out  1  one-cycle pulse: write rejected because FIFO full.
REQ-014 TXP / TXN  out  1  Manchester line drive pair.
REQ-015 en_tx  out  1  transmitter enable; high throughout a burst.
REQ-016 ce_tact  out  1  one-cycle half-bit tick.
REQ-017 cb_bit  out  clog2(DW+2)  bit-time index in current word: 0 = sync, 1..DW = data MSB first, DW+1 = parity.
REQ-018 T_end  out  1  one-cycle pulse on the last clk of each word's parity bit.

Function
REQ-019 Word frame SHALL be 3 bit-times sync + DW data bits + 1 parity bit = (DW+4)*2*DIV clk cycles.
REQ-020 SY1 sync SHALL drive TXP high for 3 half-bits then low for 3; SY2 SHALL be the inverse.
REQ-021 Data/parity bit '1' SHALL be TXP high first half, low second; '0' the inverse; MSB first.
REQ-022 Parity bit SHALL make the count of ones over data+parity odd (PAR_ODD=1) or even (PAR_ODD=0).
REQ-023 TXN SHALL equal ~TXP while en_tx=1; TXP=TXN=0 while en_tx=0.
REQ-024 FSM states IDLE, SYNC, DATA, PAR; IDLE->SYNC when !empty; SYNC->DATA after 6 half-bits; DATA->PAR after DW bits; PAR->SYNC if !empty at final parity clk, else PAR->IDLE.
REQ-025 Entering SYNC SHALL pop the FIFO head into the shift register on the same edge and reset the divider to 0.
REQ-026 Latency: word written at edge k into empty FIFO while IDLE -> en_tx=1 and first sync level on TXP after edge k+1.
REQ-027 Back-to-back words SHALL have zero gap: next sync starts on the clk after T_end.
REQ-028 ce_tact SHALL pulse every DIV clks while en_tx=1 (on the last clk of each half-bit); low in IDLE.
REQ-029 FIFO SHALL accept a write when !full; write while full SHALL be dropped and pulse ovf, even if a pop occurs the same cycle.
REQ-030 Simultaneous write and pop when not full SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-031 abort=1 SHALL, at the next edge, force IDLE, en_tx=0, TXP=TXN=0, FIFO empty, level=0; abort has priority over wr_en.
REQ-032 Changes on wr_* during a word SHALL NOT affect the word in flight.

Reset
REQ-033 rst_n=0 at an edge SHALL set IDLE, FIFO empty (empty=1, full=0, level=0), TXP=TXN=en_tx=ce_tact=T_end=ovf=0, cb_bit=0, divider=0.
REQ-034 Reset mid-word SHALL terminate the word immediately with no further line activity; reset has priority over abort and wr_en.

Verification (DW=16, DIV=2, DEPTH=4, PAR_ODD=1)
REQ-035 Write 16'hA5A5, wr_cw=1 -> en_tx high 80 clks; TXP 6 clks high, 6 low, then Manchester of A5A5, parity bit '1'; one T_end; back to IDLE.
REQ-036 Write 16'h0001, wr_cw=0 -> SY2 (TXP low 6 clks, high 6), parity bit '0'.
REQ-037 Write 3 words in consecutive cycles -> en_tx high continuously for 240 clks, 3 T_end pulses, no idle gap.
REQ-038 Write 6 words in consecutive cycles while IDLE -> first popped at once, next 4 accepted, 6th pulses ovf; 5 words transmitted.
REQ-039 abort at clk 30 of a 2-word burst -> en_tx=0, TXP=TXN=0, level=0 next cycle; no T_end.
REQ-040 rst_n=0 mid-DATA with 2 words queued -> all outputs at reset values next edge; no transmission after release until a new write.

Source files
------------

// File: rtl/mil_txd_burst.sv
// MIL-STD-1553 style Manchester word transmitter fed by a small word FIFO; words go out back-to-back with no gap.
// Latency: line active one clk after the first write into an empty FIFO; backpressure: writes while full are dropped and pulse ovf.
module mil_txd_burst #(
    parameter int DW      = 16,
    parameter int DIV     = 25,
    parameter int DEPTH   = 4,
    parameter int PAR_ODD = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_dat,
    input  logic                       wr_cw,
    input  logic                       abort,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf,
    output logic                       TXP,
    output logic                       TXN,
    output logic                       en_tx,
    output logic                       ce_tact,
    output logic [$clog2(DW+2)-1:0]    cb_bit,
    output logic                       T_end
);
    localparam int LW  = $clog2(DEPTH+1);
    localparam int PW  = $clog2(DEPTH);
    localparam int CBW = $clog2(DW+2);
    localparam int NH  = 2*(DW+4);
    localparam int HW  = $clog2(NH);
    localparam int DVW = $clog2(DIV);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV-1);
    localparam logic [HW-1:0]  H_LAST   = HW'(NH-1);
    localparam logic [HW-1:0]  H_DATA   = HW'(6);
    localparam logic [HW-1:0]  H_PAR    = HW'(6+2*DW);
    localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);
    localparam logic           PODD     = (PAR_ODD != 0);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;

    state_t          state_q, state_d;
    logic [DVW-1:0]  div_q, div_d;
    logic [HW-1:0]   half_q, half_d;
    logic [DW-1:0]   sr_q, sr_d;
    logic            cw_q, cw_d;
    logic            par_q, par_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic            txp_q, txp_d;
    logic            txn_q, txn_d;
    logic            en_tx_q, en_tx_d;
    logic            ce_q, ce_d;
    logic [CBW-1:0]  cb_q, cb_d;
    logic            tend_q, tend_d;
    logic [DW:0]     mem_q [DEPTH];
    logic [DW:0]     head;
    logic [HW-1:0]   hoff;
    logic            load, push, pop;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        sr_d    = sr_q;
        cw_d    = cw_q;
        par_d   = par_q;
        load    = 1'b0;
        head    = mem_q[rd_ptr_q];

        // half_q counts half-bits across the whole word: 0..5 sync, then data, then parity
        if (state_q == S_IDLE) begin
            load = !empty_q;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (state_q == S_DATA && half_q[0]) begin
                sr_d = {sr_q[DW-2:0], 1'b0};
            end
            if (half_q == H_LAST) begin
                load    = !empty_q;
                state_d = S_IDLE;
            end else begin
                half_d = half_q + HW'(1);
                if (half_d < H_DATA) begin
                    state_d = S_SYNC;
                end else if (half_d < H_PAR) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_PAR;
                end
            end
        end else begin
            div_d = div_q + DVW'(1);
        end

        if (load) begin
            state_d = S_SYNC;
            div_d   = '0;
            half_d  = '0;
            sr_d    = head[DW-1:0];
            cw_d    = head[DW];
            par_d   = (^head[DW-1:0]) ^ PODD;
        end
        if (abort) begin
            state_d = S_IDLE;
            div_d   = '0;
            half_d  = '0;
            load    = 1'b0;
        end

        push     = wr_en && !full_q && !abort;
        pop      = load;
        ovf_d    = wr_en && full_q && !abort;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d  = (count_d == LVL_FULL);
        empty_d = (count_d == '0);

        // Line outputs are derived from the next position so they register in step with it
        en_tx_d = (state_d != S_IDLE);
        txp_d   = 1'b0;
        cb_d    = '0;
        hoff    = half_d - H_DATA;
        case (state_d)
            S_SYNC: txp_d = cw_d ? (half_d < HW'(3)) : (half_d >= HW'(3));
            S_DATA: begin
                txp_d = sr_d[DW-1] ^ half_d[0];
                cb_d  = CBW'((hoff >> 1) + HW'(1));
            end
            S_PAR: begin
                txp_d = par_d ^ half_d[0];
                cb_d  = CBW'(DW+1);
            end
            default: ;
        endcase
        txn_d  = en_tx_d & ~txp_d;
        ce_d   = en_tx_d && (div_d == DIV_LAST);
        tend_d = (state_d == S_PAR) && (half_d == H_LAST) && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            half_q   <= '0;
            sr_q     <= '0;
            cw_q     <= 1'b0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            txp_q    <= 1'b0;
            txn_q    <= 1'b0;
            en_tx_q  <= 1'b0;
            ce_q     <= 1'b0;
            cb_q     <= '0;
            tend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sr_q     <= sr_d;
            cw_q     <= cw_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            txp_q    <= txp_d;
            txn_q    <= txn_d;
            en_tx_q  <= en_tx_d;
            ce_q     <= ce_d;
            cb_q     <= cb_d;
            tend_q   <= tend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {wr_cw, wr_dat};
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = count_q;
    assign ovf     = ovf_q;
    assign TXP     = txp_q;
    assign TXN     = txn_q;
    assign en_tx   = en_tx_q;
    assign ce_tact = ce_q;
    assign cb_bit  = cb_q;
    assign T_end   = tend_q;
endmodule
